// File: rtl/display_scan_ctrl_pkg.sv
// rtl/display_scan_ctrl_pkg.sv - shared types and constants for the display scan scheduler
//
// Purpose: scan state enum, digit width, position-count bound and the
//          leading-zero helper used by display_scan_ctrl.
// Ports:   none (package).
package display_scan_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  // Index of the most significant nonzero digit among the first n positions.
  // Returns 0 for an all-zero frame so position 0 is always shown.
  function automatic logic [2:0] top_nonzero(
    input logic [DIGIT_W*MAX_DIGITS-1:0] frame,
    input int                            n
  );
    logic [2:0] top;
    top = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n && frame[i*DIGIT_W +: DIGIT_W] != '0) begin
        top = 3'(i);
      end
    end
    return top;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - frame input and scan output bundle of the display scan scheduler
//
// Purpose: groups the counter-side frame inputs and the display-side outputs.
// Signals: enable, load, digits_in (from the counter datapath);
//          digit_code, digit_en, blank, frame_done (to seg7 / uio pins).
// Modports: master drives the frame side, slave is the scheduler.
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import display_scan_pkg::*;

  logic                          enable;
  logic                          load;
  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in;
  logic [DIGIT_W-1:0]            digit_code;
  logic [NUM_DIGITS-1:0]         digit_en;
  logic                          blank;
  logic                          frame_done;

  modport master (
    output enable, load, digits_in,
    input  digit_code, digit_en, blank, frame_done
  );

  modport slave (
    input  enable, load, digits_in,
    output digit_code, digit_en, blank, frame_done
  );

endinterface

// File: rtl/display_scan_ctrl_timer.sv
// rtl/display_scan_ctrl_timer.sv - loadable phase up-counter with terminal-count flag
//
// Purpose: module scan_timer, counts cycles spent in the current scan phase.
// Ports:   clk, reset (sync, active-high)
//          load_i / load_val_i : synchronous load (takes priority over inc_i)
//          inc_i               : count up by one
//          term_i              : terminal value compared against the count
//          next_o              : value the counter holds after the coming edge
//          tc_o                : current count equals term_i
module scan_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] term_i,
  output logic [WIDTH-1:0] next_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Exposed so the parent can register outputs aligned with the next cycle.
  assign next_o = count_d;
  assign tc_o   = (count_q == term_i);

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - time-multiplexed digit scan scheduler for a shared seg7 bus
//
// Purpose: latches BCD frames and rotates through NUM_DIGITS positions, each
//          slot being BLANK_CYCLES all-off cycles followed by DWELL_CYCLES lit.
// Ports:   clk, reset (sync, active-high, overrides everything)
//          bus (display_scan_ctrl_if.slave): enable, load, digits_in in;
//          digit_code, digit_en, blank, frame_done out (all registered).
// Option:  DISPLAY_SCAN_LZ_BLANK_EN - leading-zero suppression; positions above
//          the most significant nonzero digit stay dark but keep slot timing.
module display_scan_ctrl
  import display_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 10_000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                clk,
  input  logic                reset,
  display_scan_ctrl_if.slave  bus
);

  localparam int FW     = DIGIT_W * NUM_DIGITS;
  localparam int IW     = $clog2(NUM_DIGITS);
  localparam int MAXC   = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW     = $clog2(MAXC + 1);

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  // With no blanking gap every slot starts directly in SHOW.
  localparam scan_state_e SLOT_ENTRY = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  scan_state_e           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         pending_q, pending_d;
  logic [FW-1:0]         active_q, active_d;
  logic [DIGIT_W-1:0]    code_q, code_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  blank_q, blank_d;
  logic                  fd_q, fd_d;

  logic                  boundary;
  logic                  lit;
  logic                  tmr_load;
  logic                  tmr_tc;
  logic [TW-1:0]         tmr_term;
  logic [TW-1:0]         tmr_next;

  assign tmr_term = (state_q == ST_SHOW) ? DWELL_LAST : BLANK_LAST;

  scan_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i ('0),
    .inc_i      (state_q != ST_IDLE),
    .term_i     (tmr_term),
    .next_o     (tmr_next),
    .tc_o       (tmr_tc)
  );

  // Next-state: scan sequencing and frame capture.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmr_load  = 1'b0;
    boundary  = 1'b0;
    pending_d = bus.load ? bus.digits_in : pending_q;

    if (!bus.enable) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = SLOT_ENTRY;
          idx_d    = '0;
          tmr_load = 1'b1;
          boundary = 1'b1;
        end
        ST_BLANK: begin
          if (tmr_tc) begin
            state_d  = ST_SHOW;
            tmr_load = 1'b1;
          end
        end
        ST_SHOW: begin
          if (tmr_tc) begin
            state_d  = SLOT_ENTRY;
            tmr_load = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        default: begin
          state_d  = ST_IDLE;
          idx_d    = '0;
          tmr_load = 1'b1;
        end
      endcase
    end

    // pending_d already carries a same-cycle load, giving the bypass.
    active_d = boundary ? pending_d : active_q;
  end

`ifdef DISPLAY_SCAN_LZ_BLANK_EN
  logic [IW-1:0] lz_top_q, lz_top_d;

  always_comb begin
    lz_top_d = lz_top_q;
    if (boundary) begin
      lz_top_d = IW'(top_nonzero((DIGIT_W*MAX_DIGITS)'(active_d), NUM_DIGITS));
    end
    lit = (idx_d <= lz_top_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lz_top_q <= '0;
    end else begin
      lz_top_q <= lz_top_d;
    end
  end
`else
  assign lit = 1'b1;
`endif

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    code_d = '0;
    en_d   = '0;
    if (state_d != ST_IDLE) begin
      code_d = active_d[int'(idx_d)*DIGIT_W +: DIGIT_W];
    end
    if (state_d == ST_SHOW && lit) begin
      en_d = NUM_DIGITS'(1) << idx_d;
    end
    blank_d = ~(|en_d);
    fd_d    = (state_d == ST_SHOW) && (idx_d == LAST_IDX) && (tmr_next == DWELL_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= '0;
      active_q  <= '0;
      code_q    <= '0;
      en_q      <= '0;
      blank_q   <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      code_q    <= code_d;
      en_q      <= en_d;
      blank_q   <= blank_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.digit_code = code_q;
  assign bus.digit_en   = en_q;
  assign bus.blank      = blank_q;
  assign bus.frame_done = fd_q;

endmodule
